// File: rtl/alu_arb_ctrl.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// One operation in flight: IDLE accepts, EXEC captures the ALU result, RESP returns it.
module alu_arb_ctrl #(
  parameter int DW  = 32,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [DW-1:0]  rsp_data,
  output logic           rsp_err,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_result,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic           prio;   // 1: req1 wins a tie
  logic           owner;
  logic           err;
  logic           gnt;
  logic           accept;
  logic           rsp_hs;
  logic [OPW-1:0] sel_op;

  // Opcodes 0101 and 11xx have no ALU function behind them.
  function automatic logic is_bad_op(input logic [OPW-1:0] op);
    return (op == 4'b0101) || (op[3:2] == 2'b11);
  endfunction

  // Tie goes to the prio holder; a lone requester always wins.
  assign gnt    = (req0_valid && req1_valid) ? prio : req1_valid;
  assign accept = (state == IDLE) && (req0_valid || req1_valid);
  assign sel_op = gnt ? req1_op : req0_op;
  assign rsp_hs = owner ? rsp1_ready : rsp0_ready;

  assign req0_ready = (state == IDLE) && req0_valid && !gnt;
  assign req1_ready = (state == IDLE) && req1_valid &&  gnt;
  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) &&  owner;
  assign busy       = (state != IDLE);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prio     <= 1'b0;
      owner    <= 1'b0;
      err      <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_op <= sel_op;
        alu_a  <= gnt ? req1_a : req0_a;
        alu_b  <= gnt ? req1_b : req0_b;
        owner  <= gnt;
        err    <= is_bad_op(sel_op);
      end
      if (state == EXEC) begin
        rsp_data <= err ? '0 : alu_result;
        rsp_err  <= err;
      end
      if ((state == RESP) && rsp_hs)
        prio <= ~owner;
    end
  end

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Directed bench for alu_arb_ctrl with a small stand-in ALU; expected values are hand-computed.
module tb_alu_arb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_data, alu_a, alu_b, alu_result;
  logic        rsp_err, busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_arb_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .busy(busy)
  );

  // Stand-in ALU; unmapped opcodes return a loud pattern so forced-zero results are visible.
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0010: alu_result = alu_a & alu_b;
      4'b0011: alu_result = alu_a | alu_b;
      4'b0100: alu_result = alu_a ^ alu_b;
      4'b1000: alu_result = alu_a << alu_b[4:0];
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns the granted requester, or -1 if no ready appears within the budget.
  task automatic wait_grant(output int g);
    g = -1;
    for (int c = 0; c < 10; c++) begin
      if (req0_ready) begin g = 0; break; end
      if (req1_ready) begin g = 1; break; end
      step();
    end
    if (g < 0) check("grant_timeout", {31'd0, req0_ready | req1_ready}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Lone-requester operation with rsp_ready high: accept, EXEC, RESP, back to IDLE.
  task automatic run_op(input int n, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_d, input logic exp_e);
    int g;
    if (n == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; rsp0_ready = 1'b1;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; rsp1_ready = 1'b1;
    end
    #1;
    wait_grant(g);
    check("op_grant", g, n);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("op_exec_busy", {31'd0, busy}, 32'd1);
    check("op_alu_op", {28'd0, alu_op}, {28'd0, op});
    check("op_alu_a", alu_a, a);
    check("op_alu_b", alu_b, b);
    step();
    check("op_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, (n == 0) ? 32'd1 : 32'd2);
    check("op_rsp_data", rsp_data, exp_d);
    check("op_rsp_err", {31'd0, rsp_err}, {31'd0, exp_e});
    step();
    check("op_idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int g, n0, n1;
    rst = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    do_reset();

    // Reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);

    // Single op: 5 + 7
    run_op(0, 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0);

    // Simultaneous requests after reset: req0 first, then req1; six cycles total
    do_reset();
    req0_valid = 1'b1; req0_op = 4'b0001; req0_a = 32'd10;   req0_b = 32'd3;
    req1_valid = 1'b1; req1_op = 4'b0100; req1_a = 32'hF0;   req1_b = 32'h0F;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    check("sim_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    check("sim_hold_req1", {31'd0, req1_ready}, 32'd0);
    step();
    check("sim_rsp0_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
    check("sim_rsp0_data", rsp_data, 32'd7);
    step();
    check("sim_req1_ready", {31'd0, req1_ready}, 32'd1);
    step();
    req1_valid = 1'b0;
    step();
    check("sim_rsp1_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
    check("sim_rsp1_data", rsp_data, 32'hFF);
    step();
    check("sim_done_busy", {31'd0, busy}, 32'd0);

    // Round-robin under persistent contention
    req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'd3;  req0_b = 32'd4;
    req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'hFF; req1_b = 32'h0F;
    #1;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 8; i++) begin
      wait_grant(g);
      if (g < 0) break;
      check("rr_grant", g, i % 2);
      if (g == 0) n0++; else n1++;
      step();
      step();
      check("rr_data", rsp_data, (g == 0) ? 32'd7 : 32'h0F);
      step();
    end
    check("rr_n0", n0, 4);
    check("rr_n1", n1, 4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Response backpressure on rsp1 with req0 waiting
    req1_valid = 1'b1; req1_op = 4'b1000; req1_a = 32'd1; req1_b = 32'd4;
    rsp1_ready = 1'b0;
    #1;
    wait_grant(g);
    check("bp_grant", g, 1);
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 4'b0001; req0_a = 32'd10; req0_b = 32'd3;
    step();
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp1_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
      check("bp_data", rsp_data, 32'd16);
      check("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
      step();
    end
    rsp1_ready = 1'b1;
    step();
    check("bp_release", {31'd0, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    step();
    check("bp_req0_data", rsp_data, 32'd7);
    step();

    // Undefined opcodes: result forced to zero, error flagged, normal return to IDLE
    run_op(0, 4'b1100, 32'd1, 32'd1, 32'd0, 1'b1);
    run_op(1, 4'b0101, 32'd2, 32'd2, 32'd0, 1'b1);
    run_op(1, 4'b0011, 32'hA0, 32'h05, 32'hA5, 1'b0);

    // Reset in EXEC
    req1_valid = 1'b1; req1_op = 4'b0000; req1_a = 32'd9; req1_b = 32'd9;
    #1;
    wait_grant(g);
    step();
    req1_valid = 1'b0;
    check("rx_in_exec", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rx_busy", {31'd0, busy}, 32'd0);
    check("rx_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("rx_alu", alu_a | alu_b | {28'd0, alu_op}, 32'd0);
    step();
    check("rx_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);

    // Reset in RESP
    req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'd1; req0_b = 32'd1;
    rsp0_ready = 1'b0;
    #1;
    wait_grant(g);
    step();
    req0_valid = 1'b0;
    step();
    check("rr_in_resp", {31'd0, rsp0_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rr_busy", {31'd0, busy}, 32'd0);
    check("rr_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("rr_alu", alu_a | alu_b | {28'd0, alu_op}, 32'd0);
    check("rr_rsp", rsp_data | {31'd0, rsp_err}, 32'd0);

    // Clean acceptance after reset
    run_op(1, 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
